// File: rtl/fb_display_reader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fb_display_reader
//   Read-side controller for the RGB565 camera frame buffer. Walks the stored
//   IMG_WIDTH x IMG_HEIGHT image in raster order, in step with the VGA timing
//   generator, and repeats every stored pixel SCALE times horizontally and
//   every stored line SCALE times vertically. The buffer read data is turned
//   into 4:4:4 RGB. Syncs and DE are delayed by the two-cycle read latency so
//   the colour stays aligned with them.
//
// Ports
//   clk         pixel clock, also the frame-buffer read clock
//   reset       synchronous, active-high
//   de_in       display enable from the timing generator
//   h_sync_in   hsync from the timing generator
//   v_sync_in   vsync from the timing generator, active level = VSYNC_POL
//   oe          frame-buffer read enable (follows de_in combinationally)
//   rAddr       frame-buffer read address (registered counter)
//   rData       frame-buffer read data, RGB565, valid one cycle after oe
//   de_out      de_in delayed by two cycles
//   h_sync_out  h_sync_in delayed by two cycles
//   v_sync_out  v_sync_in delayed by two cycles
//   red/green/blue  registered 4-bit colour, zero outside the active area
// -----------------------------------------------------------------------------
module fb_display_reader #(
    parameter int   IMG_WIDTH  = 160,
    parameter int   IMG_HEIGHT = 120,
    parameter int   SCALE      = 4,
    parameter int   ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT),
    parameter logic VSYNC_POL  = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  de_in,
    input  logic                  h_sync_in,
    input  logic                  v_sync_in,
    output logic                  oe,
    output logic [ADDR_WIDTH-1:0] rAddr,
    input  logic [15:0]           rData,
    output logic                  de_out,
    output logic                  h_sync_out,
    output logic                  v_sync_out,
    output logic [3:0]            red,
    output logic [3:0]            green,
    output logic [3:0]            blue
);

    localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [SUB_W-1:0]    SUB_LAST    = SUB_W'(SCALE - 1);
    // One extra bit so base + width and the frame-size compare never overflow.
    localparam logic [ADDR_WIDTH:0] LINE_STEP   = (ADDR_WIDTH + 1)'(IMG_WIDTH);
    localparam logic [ADDR_WIDTH:0] LAST_COL    = (ADDR_WIDTH + 1)'(IMG_WIDTH - 1);
    localparam logic [ADDR_WIDTH:0] FRAME_WORDS = (ADDR_WIDTH + 1)'(IMG_WIDTH * IMG_HEIGHT);
    localparam logic HSYNC_IDLE = 1'b1;
    localparam logic VSYNC_IDLE = ~VSYNC_POL;

    // RGB565 -> 4:4:4 by keeping the top four bits of each field.
    function automatic logic [11:0] rgb565_to_444(input logic [15:0] px);
        return {px[15:12], px[10:7], px[4:1]};
    endfunction

    logic [ADDR_WIDTH-1:0] addr_cnt_q,  addr_cnt_d;
    logic [ADDR_WIDTH-1:0] line_base_q, line_base_d;
    logic [SUB_W-1:0]      col_sub_q,   col_sub_d;
    logic [SUB_W-1:0]      row_sub_q,   row_sub_d;
    logic                  de_prev_q,   de_prev_d;

    logic                  de_d1_q, de_d1_d, de_d2_q, de_d2_d;
    logic                  hs_d1_q, hs_d1_d, hs_d2_q, hs_d2_d;
    logic                  vs_d1_q, vs_d1_d, vs_d2_q, vs_d2_d;
    logic [11:0]           rgb_q,   rgb_d;

    logic                  vsync_active_s;
    logic                  line_end_s;
    logic [ADDR_WIDTH:0]   row_limit_s;
    logic [ADDR_WIDTH:0]   next_base_s;

    // rData bits dropped by the 565 -> 444 truncation.
    logic                  unused_rdata_s;
    assign unused_rdata_s = ^{rData[11], rData[6:5], rData[0]};

    // Address walk: vsync clear, end-of-line repeat/advance, horizontal stepping.
    always_comb begin
        addr_cnt_d     = addr_cnt_q;
        line_base_d    = line_base_q;
        col_sub_d      = col_sub_q;
        row_sub_d      = row_sub_q;
        de_prev_d      = de_in;
        vsync_active_s = (v_sync_in == VSYNC_POL);
        line_end_s     = de_prev_q & ~de_in;
        row_limit_s    = {1'b0, line_base_q} + LAST_COL;
        next_base_s    = {1'b0, line_base_q} + LINE_STEP;

        if (vsync_active_s) begin
            // Also wins over a coincident end of line.
            addr_cnt_d  = '0;
            line_base_d = '0;
            col_sub_d   = '0;
            row_sub_d   = '0;
            de_prev_d   = 1'b0;
        end else if (line_end_s) begin
            col_sub_d = '0;
            if (row_sub_q < SUB_LAST) begin
                // Replay the same stored line.
                row_sub_d  = row_sub_q + 1'b1;
                addr_cnt_d = line_base_q;
            end else begin
                row_sub_d = '0;
                if (next_base_s >= FRAME_WORDS) begin
                    line_base_d = '0;
                    addr_cnt_d  = '0;
                end else begin
                    line_base_d = next_base_s[ADDR_WIDTH-1:0];
                    addr_cnt_d  = next_base_s[ADDR_WIDTH-1:0];
                end
            end
        end else if (de_in) begin
            if (col_sub_q == SUB_LAST) begin
                col_sub_d = '0;
                // Over-long lines keep re-reading the last stored column.
                if ({1'b0, addr_cnt_q} < row_limit_s) begin
                    addr_cnt_d = addr_cnt_q + 1'b1;
                end else begin
                    addr_cnt_d = addr_cnt_q;
                end
            end else begin
                col_sub_d = col_sub_q + 1'b1;
            end
        end else begin
            // Blanking: hold position.
            addr_cnt_d = addr_cnt_q;
        end
    end

    // Output pipeline: two-stage sync/DE delay and colour capture one cycle after oe.
    always_comb begin
        de_d1_d = de_in;
        de_d2_d = de_d1_q;
        hs_d1_d = h_sync_in;
        hs_d2_d = hs_d1_q;
        vs_d1_d = v_sync_in;
        vs_d2_d = vs_d1_q;
        if (de_d1_q) begin
            rgb_d = rgb565_to_444(rData);
        end else begin
            rgb_d = 12'h000;
        end
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_cnt_q  <= '0;
            line_base_q <= '0;
            col_sub_q   <= '0;
            row_sub_q   <= '0;
            de_prev_q   <= 1'b0;
            de_d1_q     <= 1'b0;
            de_d2_q     <= 1'b0;
            hs_d1_q     <= HSYNC_IDLE;
            hs_d2_q     <= HSYNC_IDLE;
            vs_d1_q     <= VSYNC_IDLE;
            vs_d2_q     <= VSYNC_IDLE;
            rgb_q       <= 12'h000;
        end else begin
            addr_cnt_q  <= addr_cnt_d;
            line_base_q <= line_base_d;
            col_sub_q   <= col_sub_d;
            row_sub_q   <= row_sub_d;
            de_prev_q   <= de_prev_d;
            de_d1_q     <= de_d1_d;
            de_d2_q     <= de_d2_d;
            hs_d1_q     <= hs_d1_d;
            hs_d2_q     <= hs_d2_d;
            vs_d1_q     <= vs_d1_d;
            vs_d2_q     <= vs_d2_d;
            rgb_q       <= rgb_d;
        end
    end

    assign oe         = de_in;
    assign rAddr      = addr_cnt_q;
    assign de_out     = de_d2_q;
    assign h_sync_out = hs_d2_q;
    assign v_sync_out = vs_d2_q;
    assign red        = rgb_q[11:8];
    assign green      = rgb_q[7:4];
    assign blue       = rgb_q[3:0];

endmodule

// File: tb/tb_fb_display_reader.sv
`timescale 1ns/1ps
module tb_fb_display_reader;

    localparam int W  = 160;
    localparam int H  = 120;
    localparam int S  = 4;
    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          de_in = 1'b0;
    logic          h_sync_in = 1'b1;
    logic          v_sync_in = 1'b1;
    logic          oe;
    logic [AW-1:0] rAddr;
    logic [15:0]   rData = 16'h0000;
    logic          de_out, h_sync_out, v_sync_out;
    logic [3:0]    red, green, blue;

    logic          ovr_en = 1'b0;
    logic [15:0]   ovr_val = 16'h0000;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fb_display_reader #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .SCALE     (S),
        .ADDR_WIDTH(AW),
        .VSYNC_POL (1'b0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .de_in     (de_in),
        .h_sync_in (h_sync_in),
        .v_sync_in (v_sync_in),
        .oe        (oe),
        .rAddr     (rAddr),
        .rData     (rData),
        .de_out    (de_out),
        .h_sync_out(h_sync_out),
        .v_sync_out(v_sync_out),
        .red       (red),
        .green     (green),
        .blue      (blue)
    );

    // Frame-buffer content: an address hash, or an override for chosen pixels.
    function automatic logic [15:0] pix(input logic [AW-1:0] a);
        logic [31:0] p;
        p = {17'd0, a} * 32'd40503;
        return p[15:0] ^ 16'hC3A5;
    endfunction

    function automatic logic [11:0] to444(input logic [15:0] d);
        return {d[15:12], d[10:7], d[4:1]};
    endfunction

    // Synchronous-read RAM model, one cycle latency.
    always @(posedge clk) begin
        if (oe) rData <= ovr_en ? ovr_val : pix(rAddr);
    end

    // Raster model: position from the driven stimulus only.
    logic        trk = 1'b0, pd = 1'b0, started = 1'b0;
    int          x = 0, y = 0;
    logic        de1 = 1'b0, de2 = 1'b0, hs1 = 1'b1, hs2 = 1'b1, vs1 = 1'b1, vs2 = 1'b1;
    logic        rst1 = 1'b0, rst2 = 1'b0, tv1 = 1'b0, tv2 = 1'b0;
    logic [15:0] rd1 = 16'h0000, rd2 = 16'h0000;
    logic [31:0] last_de_addr = 32'd0, max_addr = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock window: drive inputs at negedge, check outputs, advance the model.
    task automatic cycle(input logic de, input logic hs, input logic vs, input logic rst,
                         input logic oen, input logic [15:0] ov);
        int          col;
        int          ea;
        logic [15:0] erd;
        @(negedge clk);
        reset = rst; de_in = de; h_sync_in = hs; v_sync_in = vs;
        ovr_en = oen; ovr_val = ov;
        #1;
        col = (x / S > W - 1) ? W - 1 : x / S;
        ea  = ((y / S) % H) * W + col;
        if (started) begin
            chk("oe", {31'd0, oe}, {31'd0, de});
            if (trk) chk("rAddr", {17'd0, rAddr}, ea);
            chk("de_out", {31'd0, de_out}, {31'd0, (!rst1 && !rst2 && de2)});
            chk("h_sync_out", {31'd0, h_sync_out}, {31'd0, ((rst1 || rst2) ? 1'b1 : hs2)});
            chk("v_sync_out", {31'd0, v_sync_out}, {31'd0, ((rst1 || rst2) ? 1'b1 : vs2)});
            if (rst1 || rst2 || !de2) chk("rgb_blank", {20'd0, red, green, blue}, 32'd0);
            else if (tv2) chk("rgb", {20'd0, red, green, blue}, {20'd0, to444(rd2)});
        end
        if (de) begin
            last_de_addr = {17'd0, rAddr};
            if ({17'd0, rAddr} > max_addr) max_addr = {17'd0, rAddr};
        end
        erd = oen ? ov : pix(ea[AW-1:0]);
        de2 = de1; hs2 = hs1; vs2 = vs1; rst2 = rst1; tv2 = tv1; rd2 = rd1;
        de1 = de;  hs1 = hs;  vs1 = vs;  rst1 = rst;  tv1 = trk && de; rd1 = erd;
        if (rst || !vs) begin
            trk = 1'b1; x = 0; y = 0; pd = 1'b0;
        end else if (de) begin
            x++; pd = 1'b1;
        end else if (pd) begin
            x = 0; y++; pd = 1'b0;
        end
        started = 1'b1;
    endtask

    task automatic run_line(input int len, input int blank);
        for (int i = 0; i < len; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < blank; i++)
            cycle(1'b0, (i == 1 || i == 2) ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic vsync_seq();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    endtask

    typedef struct {
        logic        de;
        logic        hs;
        logic        ovr;
        logic [15:0] rd;
        logic [AW-1:0] exp_addr;
        logic        exp_de_out;
        logic [11:0] exp_rgb;
        logic        exp_hs;
    } vec_t;

    vec_t tbl [11];

    initial begin
        // Short lines right after a vsync: 4-pixel line, then a 1-pixel line.
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 16'hF81F, 15'd0, 1'b0, 12'h000, 1'b1};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 16'h07E0, 15'd0, 1'b0, 12'h000, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 16'h001E, 15'd0, 1'b1, 12'hF0F, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 16'hA5A5, 15'd0, 1'b1, 12'h0F0, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 15'd1, 1'b1, 12'h00F, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 15'd0, 1'b1, 12'hAB2, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 15'd0, 1'b0, 12'h000, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 16'hFFFF, 15'd0, 1'b0, 12'h000, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 15'd0, 1'b0, 12'h000, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 15'd0, 1'b1, 12'hFFF, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 15'd0, 1'b0, 12'h000, 1'b1};

        // Reset for 3 cycles, then release with de low.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("rst_rAddr", {17'd0, rAddr}, 32'd0);
        chk("rst_oe", {31'd0, oe}, 32'd0);
        chk("rst_de_out", {31'd0, de_out}, 32'd0);
        chk("rst_rgb", {20'd0, red, green, blue}, 32'd0);
        chk("rst_vsync_idle", {31'd0, v_sync_out}, 32'd1);

        // Colour mapping and latency vectors.
        vsync_seq();
        for (int k = 0; k < 11; k++) begin
            cycle(tbl[k].de, tbl[k].hs, 1'b1, 1'b0, tbl[k].ovr, tbl[k].rd);
            chk("tbl_rAddr", {17'd0, rAddr}, {17'd0, tbl[k].exp_addr});
            chk("tbl_de_out", {31'd0, de_out}, {31'd0, tbl[k].exp_de_out});
            chk("tbl_rgb", {20'd0, red, green, blue}, {20'd0, tbl[k].exp_rgb});
            chk("tbl_hs", {31'd0, h_sync_out}, {31'd0, tbl[k].exp_hs});
        end

        // Whole frame: full lines at the top and bottom, short lines in between.
        vsync_seq();
        for (int l = 0; l < 4; l++) run_line(640, 4);
        chk("line4_base", {17'd0, rAddr}, 32'd160);
        run_line(640, 4);
        chk("line4_end", last_de_addr, 32'd319);
        for (int l = 5; l < 476; l++) run_line(8, 4);
        for (int l = 476; l < 480; l++) run_line(640, 4);
        chk("line479_end", last_de_addr, 32'd19199);
        chk("frame_wrap_base", {17'd0, rAddr}, 32'd0);
        run_line(8, 4);

        // Over-long line clamps at the end of the stored line.
        vsync_seq();
        for (int l = 0; l < 4; l++) run_line(8, 4);
        run_line(700, 4);
        chk("overlong_clamp", last_de_addr, 32'd319);
        chk("after_overlong_base", {17'd0, rAddr}, 32'd160);
        run_line(640, 4);
        chk("line5_end", last_de_addr, 32'd319);

        // vsync coinciding with de falling, mid-frame at line 100.
        for (int l = 6; l < 100; l++) run_line(8, 4);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("vsync_mid_addr", {17'd0, rAddr}, 32'd0);
        for (int l = 0; l < 4; l++) run_line(8, 4);
        chk("after_vsync_line4", {17'd0, rAddr}, 32'd160);

        // Reset in the middle of line 200 with de high, then a fresh frame.
        for (int l = 4; l < 200; l++) run_line(8, 4);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("reset_mid_addr", {17'd0, rAddr}, 32'd0);
        chk("reset_mid_de_out", {31'd0, de_out}, 32'd0);
        chk("reset_mid_rgb", {20'd0, red, green, blue}, 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        vsync_seq();
        chk("new_frame_addr", {17'd0, rAddr}, 32'd0);
        for (int l = 0; l < 4; l++) run_line(640, 4);
        chk("new_frame_line4", {17'd0, rAddr}, 32'd160);
        run_line(640, 4);

        chk("no_out_of_range", {31'd0, (max_addr <= 32'd19199)}, 32'd1);
        chk("max_addr_reached", max_addr, 32'd19199);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
